// File: rtl/mult_bank_server.sv
// mult_bank_server: shared lane-parallel fixed-point multiplier bank with two
// round-robin arbitrated initiator ports (A = Jacobian, B = forward kinematics).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   a_req / b_req           request, held by the initiator until granted
//   a_dataa/a_datab (b_*)   LANES x W operand lanes, captured on the grant edge
//   a_gnt / b_gnt           combinational grant, at most one per cycle
//   a_valid / b_valid       one-cycle result pulse, LATENCY cycles after grant
//   a_result / b_result     rescaled LANES x W products, held between pulses
//
// Build option: define MULT_BANK_SAT_EN to saturate each rescaled lane to the
// W-bit signed range; left undefined, lanes wrap (low W bits kept).
module mult_bank_server #(
  parameter int unsigned LANES   = 36,
  parameter int unsigned W       = 27,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               a_req,
  input  logic [LANES*W-1:0] a_dataa,
  input  logic [LANES*W-1:0] a_datab,
  output logic               a_gnt,
  output logic               a_valid,
  output logic [LANES*W-1:0] a_result,
  input  logic               b_req,
  input  logic [LANES*W-1:0] b_dataa,
  input  logic [LANES*W-1:0] b_datab,
  output logic               b_gnt,
  output logic               b_valid,
  output logic [LANES*W-1:0] b_result
);

  localparam int unsigned VW  = LANES * W;
  localparam int unsigned PW  = LANES * 2 * W;
  localparam int unsigned NPS = (LATENCY > 2) ? LATENCY - 2 : 1;

  localparam logic [2*W-1:0] HALF = {{(2*W-1){1'b0}}, 1'b1} << (FRAC - 1);
`ifdef MULT_BANK_SAT_EN
  localparam logic signed [2*W-1:0] SAT_MAX = (2*W)'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [2*W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} rr_e;

  rr_e             rr_q, rr_d;
  logic            s0_valid_q, s0_valid_d;
  logic            s0_tag_q, s0_tag_d;
  logic [VW-1:0]   s0_a_q, s0_a_d;
  logic [VW-1:0]   s0_b_q, s0_b_d;
  logic [PW-1:0]   prod0;
  logic [2*W-1:0]  ext_a, ext_b;
  logic            fin_valid, fin_tag;
  logic [PW-1:0]   fin_prod;
  logic [VW-1:0]   rsc;
  logic            a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [VW-1:0]   a_result_q, a_result_d, b_result_q, b_result_d;

  // Round to nearest (half up), arithmetic shift, then narrow to W bits.
  function automatic logic [W-1:0] rescale(input logic [2*W-1:0] p);
    logic signed [2*W-1:0] r;
    r = $signed(p + HALF) >>> FRAC;
`ifdef MULT_BANK_SAT_EN
    if (r > SAT_MAX)      rescale = SAT_MAX[W-1:0];
    else if (r < SAT_MIN) rescale = SAT_MIN[W-1:0];
    else                  rescale = r[W-1:0];
`else
    rescale = r[W-1:0];
`endif
  endfunction

  // Round-robin arbiter; rr_q names the port that wins a tie.
  always_comb begin
    rr_d  = rr_q;
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_n) begin
      if (a_req && (!b_req || rr_q == PRI_A)) begin
        a_gnt = 1'b1;
        rr_d  = PRI_B;
      end else if (b_req) begin
        b_gnt = 1'b1;
        rr_d  = PRI_A;
      end
    end
  end

  // Stage 0: capture winning operands with valid and port tag.
  always_comb begin
    s0_valid_d = a_gnt | b_gnt;
    s0_tag_d   = b_gnt;
    s0_a_d     = s0_a_q;
    s0_b_d     = s0_b_q;
    if (a_gnt) begin
      s0_a_d = a_dataa;
      s0_b_d = a_datab;
    end else if (b_gnt) begin
      s0_a_d = b_dataa;
      s0_b_d = b_datab;
    end
  end

  // Full-width signed product per lane; operands sign-extended to 2W first.
  always_comb begin
    prod0 = '0;
    ext_a = '0;
    ext_b = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      ext_a = {{W{s0_a_q[l*W+W-1]}}, s0_a_q[l*W +: W]};
      ext_b = {{W{s0_b_q[l*W+W-1]}}, s0_b_q[l*W +: W]};
      prod0[l*2*W +: 2*W] = ext_a * ext_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q       <= PRI_A;
      s0_valid_q <= 1'b0;
      s0_tag_q   <= 1'b0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      s0_valid_q <= s0_valid_d;
      s0_tag_q   <= s0_tag_d;
      s0_a_q     <= s0_a_d;
      s0_b_q     <= s0_b_d;
    end
  end

  generate
    if (LATENCY > 2) begin : g_pipe
      logic          ps_valid_q [NPS];
      logic          ps_valid_d [NPS];
      logic          ps_tag_q   [NPS];
      logic          ps_tag_d   [NPS];
      logic [PW-1:0] ps_prod_q  [NPS];
      logic [PW-1:0] ps_prod_d  [NPS];

      // Product delay line between stage 0 and the rescale stage.
      always_comb begin
        ps_valid_d[0] = s0_valid_q;
        ps_tag_d[0]   = s0_tag_q;
        ps_prod_d[0]  = prod0;
        for (int unsigned i = 1; i < NPS; i++) begin
          ps_valid_d[i] = ps_valid_q[i-1];
          ps_tag_d[i]   = ps_tag_q[i-1];
          ps_prod_d[i]  = ps_prod_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int unsigned i = 0; i < NPS; i++) begin
            ps_valid_q[i] <= 1'b0;
            ps_tag_q[i]   <= 1'b0;
            ps_prod_q[i]  <= '0;
          end
        end else begin
          for (int unsigned i = 0; i < NPS; i++) begin
            ps_valid_q[i] <= ps_valid_d[i];
            ps_tag_q[i]   <= ps_tag_d[i];
            ps_prod_q[i]  <= ps_prod_d[i];
          end
        end
      end

      assign fin_valid = ps_valid_q[NPS-1];
      assign fin_tag   = ps_tag_q[NPS-1];
      assign fin_prod  = ps_prod_q[NPS-1];
    end else begin : g_direct
      // LATENCY == 2: multiply and rescale both happen after stage 0.
      assign fin_valid = s0_valid_q;
      assign fin_tag   = s0_tag_q;
      assign fin_prod  = prod0;
    end
  endgenerate

  // Last stage: rescale and steer into the tagged port's result register.
  always_comb begin
    a_valid_d  = fin_valid && !fin_tag;
    b_valid_d  = fin_valid && fin_tag;
    a_result_d = a_result_q;
    b_result_d = b_result_q;
    rsc        = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      rsc[l*W +: W] = rescale(fin_prod[l*2*W +: 2*W]);
    end
    if (a_valid_d) a_result_d = rsc;
    if (b_valid_d) b_result_d = rsc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      a_result_q <= '0;
      b_result_q <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      a_result_q <= a_result_d;
      b_result_q <= b_result_d;
    end
  end

  assign a_valid  = a_valid_q;
  assign b_valid  = b_valid_q;
  assign a_result = a_result_q;
  assign b_result = b_result_q;

endmodule

// File: tb/tb_mult_bank_server.sv
// Testbench for mult_bank_server: directed steps with a per-port scoreboard of
// expected results and their due cycle.
module tb_mult_bank_server;

  localparam int unsigned LANES   = 36;
  localparam int unsigned W       = 27;
  localparam int unsigned FRAC    = 16;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned VW      = LANES * W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, b_req = 1'b0;
  logic [VW-1:0] a_dataa = '0, a_datab = '0, b_dataa = '0, b_datab = '0;
  logic          a_gnt, a_valid, b_gnt, b_valid;
  logic [VW-1:0] a_result, b_result;

  typedef struct {
    logic [VW-1:0] data;
    int            due;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [VW-1:0] last_a = '0, last_b = '0;
  logic          ptr_b = 1'b0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  mult_bank_server #(
    .LANES(LANES), .W(W), .FRAC(FRAC), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_dataa(a_dataa), .a_datab(a_datab),
    .a_gnt(a_gnt), .a_valid(a_valid), .a_result(a_result),
    .b_req(b_req), .b_dataa(b_dataa), .b_datab(b_datab),
    .b_gnt(b_gnt), .b_valid(b_valid), .b_result(b_result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p, r;
    p = longint'($signed(x)) * longint'($signed(y));
    r = (p + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef MULT_BANK_SAT_EN
    if (r > (longint'(1) <<< (W - 1)) - 1) r = (longint'(1) <<< (W - 1)) - 1;
    if (r < -(longint'(1) <<< (W - 1)))    r = -(longint'(1) <<< (W - 1));
`endif
    return W'(r);
  endfunction

  function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [VW-1:0] v;
    v = '0;
    for (int l = 0; l < int'(LANES); l++) v[l*W +: W] = model(x[l*W +: W], y[l*W +: W]);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int l = 0; l < int'(LANES); l++) v[l*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_lane(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    int first;
    total++;
    assert (obs === exp) else begin
      bad++;
      first = 0;
      for (int l = int'(LANES) - 1; l >= 0; l--)
        if (obs[l*W +: W] !== exp[l*W +: W]) first = l;
      $error("FAIL %s cycle=%0d lane=%0d observed=%h expected=%h",
             tag, cyc, first, obs[first*W +: W], exp[first*W +: W]);
    end
  endtask

  // One clock: check grants before the edge, valids/results just after it.
  task automatic step();
    exp_t e;
    logic ega, egb, eva, evb;
    if (!reset_n) begin
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
      ptr_b  = 1'b0;
    end
    #2;
    ega = reset_n && a_req && (!b_req || !ptr_b);
    egb = reset_n && b_req && !ega;
    check_bit("a_gnt", a_gnt, ega);
    check_bit("b_gnt", b_gnt, egb);
    if (ega) begin
      e.data = model_vec(a_dataa, a_datab);
      e.due  = cyc + int'(LATENCY);
      qa.push_back(e);
      ptr_b = 1'b1;
    end
    if (egb) begin
      e.data = model_vec(b_dataa, b_datab);
      e.due  = cyc + int'(LATENCY);
      qb.push_back(e);
      ptr_b = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    eva = (qa.size() > 0) && (qa[0].due == cyc);
    evb = (qb.size() > 0) && (qb[0].due == cyc);
    check_bit("a_valid", a_valid, eva);
    check_bit("b_valid", b_valid, evb);
    if (eva) begin
      e = qa.pop_front();
      last_a = e.data;
    end
    if (evb) begin
      e = qb.pop_front();
      last_b = e.data;
    end
    check_vec("a_result", a_result, last_a);
    check_vec("b_result", b_result, last_b);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // In reset: outputs cleared and a pending request is not granted.
    step();
    a_req = 1'b1;
    a_dataa = rand_vec();
    a_datab = rand_vec();
    step();

    // Reset release with A requesting; directed lanes from the test plan.
    reset_n = 1'b1;
    a_dataa = rand_vec();
    a_datab = rand_vec();
    a_dataa[0*W +: W] = 27'h0020000;  a_datab[0*W +: W] = 27'h0030000;
    a_dataa[1*W +: W] = 27'h0000001;  a_datab[1*W +: W] = 27'h0008000;
    a_dataa[2*W +: W] = 27'h3E80000;  a_datab[2*W +: W] = 27'h0020000;
    a_dataa[5*W +: W] = 27'h7FE8000;  a_datab[5*W +: W] = 27'h0020000;
    step();
    a_req = 1'b0;
    a_dataa = '0;
    step();
    step();
    check_bit("t1_valid_at_3", a_valid, 1'b1);
    check_lane("mul_2x3", a_result[0*W +: W], 27'h0060000);
    check_lane("round_half", a_result[1*W +: W], 27'h0000001);
    check_lane("neg_1p5x2", a_result[5*W +: W], 27'h7FD0000);
`ifdef MULT_BANK_SAT_EN
    check_lane("overflow", a_result[2*W +: W], 27'h3FFFFFF);
`else
    check_lane("overflow", a_result[2*W +: W], 27'h7D00000);
`endif

    // B alone, then a one-cycle B request losing to A.
    b_req = 1'b1;
    b_dataa = rand_vec();
    b_datab = rand_vec();
    step();
    a_req = 1'b1;
    a_dataa = rand_vec();
    a_datab = rand_vec();
    b_dataa = rand_vec();
    step();
    a_req = 1'b0;
    b_req = 1'b0;
    step();

    // Continuous contention with fresh operands each cycle.
    for (int i = 0; i < 4; i++) begin
      a_req = 1'b1;
      b_req = 1'b1;
      a_dataa = rand_vec();
      a_datab = rand_vec();
      b_dataa = rand_vec();
      b_datab = rand_vec();
      step();
    end
    a_req = 1'b0;
    b_req = 1'b0;

    // Back-to-back A requests; ordering within the port.
    for (int i = 0; i < 3; i++) begin
      a_req = 1'b1;
      a_dataa = rand_vec();
      a_datab = rand_vec();
      step();
    end
    a_req = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Reset pulse one cycle after an A grant discards the request.
    a_req = 1'b1;
    a_dataa = rand_vec();
    a_datab = rand_vec();
    step();
    a_req = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    check_bit("rst_no_valid", a_valid, 1'b0);
    check_vec("rst_result_zero", a_result, '0);

    // A fresh grant after reset completes normally.
    a_req = 1'b1;
    a_dataa = rand_vec();
    a_datab = rand_vec();
    step();
    a_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_bit("drained", (qa.size() == 0) && (qb.size() == 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
